// File: rtl/matrix_key_scan_pkg.sv
// Shared definitions for the keypad scanner.
// Contents:
//   row_state_t         - the four row-scan states R0..R3
//   ROW_R0..ROW_R3      - active-low row drive pattern for each state
//   KEY_*               - calculator meaning of each key_out/key_pulse bit (row*4 + col)
//   row_drive()         - maps a scan state to its row drive pattern
package matrix_key_scan_pkg;

   typedef enum logic [1:0] {R0, R1, R2, R3} row_state_t;

   localparam logic [3:0] ROW_R0 = 4'b1110;
   localparam logic [3:0] ROW_R1 = 4'b1101;
   localparam logic [3:0] ROW_R2 = 4'b1011;
   localparam logic [3:0] ROW_R3 = 4'b0111;

   localparam int KEY_1   = 0;
   localparam int KEY_2   = 1;
   localparam int KEY_3   = 2;
   localparam int KEY_ADD = 3;
   localparam int KEY_4   = 4;
   localparam int KEY_5   = 5;
   localparam int KEY_6   = 6;
   localparam int KEY_SUB = 7;
   localparam int KEY_7   = 8;
   localparam int KEY_8   = 9;
   localparam int KEY_9   = 10;
   localparam int KEY_MUL = 11;
   localparam int KEY_0   = 12;
   localparam int KEY_CLR = 13;
   localparam int KEY_EQ  = 14;
   localparam int KEY_DIV = 15;

   function automatic logic [3:0] row_drive(input row_state_t s);
      case (s)
         R0:      row_drive = ROW_R0;
         R1:      row_drive = ROW_R1;
         R2:      row_drive = ROW_R2;
         default: row_drive = ROW_R3;
      endcase
   endfunction

endpackage

// File: rtl/matrix_key_scan_if.sv
// Keypad-side and consumer-side signals of the scanner.
//   col       - keypad columns, pulled up, 0 = key in the driven row pressed
//   row       - keypad row drive, exactly one bit low
//   key_out   - debounced level per key, bit = row*4 + col
//   key_pulse - one-clk pulse per key on debounced press
// Modports: master = scanner, slave = keypad/consumer side.
interface matrix_key_scan_if;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [15:0] key_out;
   logic [15:0] key_pulse;

   modport master (input col, output row, output key_out, output key_pulse);
   modport slave  (output col, input row, input key_out, input key_pulse);
endinterface

// File: rtl/matrix_key_scan_key_debounce.sv
// Single-key debouncer: level changes only after DEB_FRAMES consecutive
// samples that disagree with it; any agreeing sample restarts the count.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   sample_en  - high on this key's sample instant
//   raw        - raw pressed state (1 = pressed), valid when sample_en
//   level      - debounced level, 1 = pressed
//   pulse      - one-clk pulse on the edge level goes 0->1
module key_debounce #(
   parameter int DEB_FRAMES = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sample_en,
   input  logic raw,
   output logic level,
   output logic pulse
);

   localparam int CW = (DEB_FRAMES > 1) ? $clog2(DEB_FRAMES) : 1;

   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
         pulse <= 1'b0;
      end else begin
         pulse <= 1'b0;
         if (sample_en) begin
            if (raw == level) begin
               cnt <= '0;
            end else if (cnt == CW'(DEB_FRAMES - 1)) begin
               level <= raw;
               cnt   <= '0;
               pulse <= raw;   // press only; release stays silent
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/matrix_key_scan.sv
// 4x4 keypad scanner: drives one row low per slot of SCAN_DIV clocks,
// samples the synchronised columns at the end of the slot, and debounces
// each of the 16 keys independently.
// Ports:
//   clk   - system clock (12 MHz)
//   rst_n - asynchronous active-low reset
//   bus   - keypad/consumer interface (col in; row, key_out, key_pulse out)
module matrix_key_scan
   import matrix_key_scan_pkg::*;
#(
   parameter int SCAN_DIV   = 12000,
   parameter int DEB_FRAMES = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   matrix_key_scan_if.master   bus
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [3:0]       col_meta;
   logic [3:0]       col_sync;
   logic [DIV_W-1:0] div_cnt;
   row_state_t       state;
   row_state_t       state_next;
   logic             slot_end;
   logic [3:0]       row_sample;
   logic [15:0]      key_out;
   logic [15:0]      key_pulse;

   // Columns idle high, so the synchroniser resets to "nothing pressed".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_meta <= 4'b1111;
         col_sync <= 4'b1111;
      end else begin
         col_meta <= bus.col;
         col_sync <= col_meta;
      end
   end

   assign slot_end   = (div_cnt == DIV_W'(SCAN_DIV - 1));
   assign state_next = row_state_t'(2'(state + 2'd1));

   // Sampling at slot end gives the row SCAN_DIV-1 cycles to settle before
   // its columns are used; the row advances on that same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= R0;
         div_cnt <= '0;
         bus.row <= ROW_R0;
      end else if (slot_end) begin
         state   <= state_next;
         div_cnt <= '0;
         bus.row <= row_drive(state_next);
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // One-hot enable of the row whose keys are sampled this cycle.
   assign row_sample = slot_end ? (4'b0001 << state) : 4'b0000;

   for (genvar i = 0; i < 16; i++) begin : g_key
      key_debounce #(
         .DEB_FRAMES (DEB_FRAMES)
      ) u_debounce (
         .clk       (clk),
         .rst_n     (rst_n),
         .sample_en (row_sample[i / 4]),
         .raw       (~col_sync[i % 4]),
         .level     (key_out[i]),
         .pulse     (key_pulse[i])
      );
   end

   assign bus.key_out   = key_out;
   assign bus.key_pulse = key_pulse;

endmodule

// File: tb/tb_matrix_key_scan.sv
// Bench for matrix_key_scan with SCAN_DIV=4, DEB_FRAMES=3. A keypad model
// turns the held-key mask into column levels from the driven row; a
// reference model derives scan phase from the edge count since reset and
// applies the "N consecutive differing samples" rule per key.
module tb_matrix_key_scan;

   localparam int SCAN_DIV   = 4;
   localparam int DEB_FRAMES = 3;
   localparam int FRAME      = 4 * SCAN_DIV;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [15:0] held = '0;

   int n_cmp = 0;
   int n_bad = 0;

   matrix_key_scan_if kif ();

   matrix_key_scan #(
      .SCAN_DIV   (SCAN_DIV),
      .DEB_FRAMES (DEB_FRAMES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (kif.master)
   );

   always #5 clk = ~clk;

   // Keypad: a column reads 0 when a held key in a driven (low) row sits on it.
   always_comb begin
      kif.col = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!kif.row[r] && held[r*4+c]) kif.col[c] = 1'b0;
   end

   // ---------------- reference model ----------------
   int          m_n;          // clock edges since reset release
   logic [15:0] m_level;
   logic [15:0] m_pulse;
   int          m_streak [16];
   logic [15:0] m_d1, m_d2;   // held mask as seen through the 2-flop synchroniser

   function automatic logic [3:0] exp_row();
      return ~(4'b0001 << ((m_n / SCAN_DIV) % 4));
   endfunction

   task automatic model_reset();
      m_n = 0;
      m_level = '0;
      m_pulse = '0;
      m_d1 = '0;
      m_d2 = '0;
      for (int i = 0; i < 16; i++) m_streak[i] = 0;
   endtask

   // Advance one clock: update the model for the edge, then settle at negedge.
   task automatic tick();
      @(posedge clk);
      if (rst_n) begin
         m_n++;
         m_pulse = '0;
         if (m_n % SCAN_DIV == 0) begin
            int r;
            r = ((m_n / SCAN_DIV) - 1) % 4;
            for (int c = 0; c < 4; c++) begin
               int k;
               k = r * 4 + c;
               if (m_d2[k] != m_level[k]) begin
                  m_streak[k]++;
                  if (m_streak[k] == DEB_FRAMES) begin
                     m_level[k]  = m_d2[k];
                     m_pulse[k]  = m_d2[k];
                     m_streak[k] = 0;
                  end
               end else begin
                  m_streak[k] = 0;
               end
            end
         end
         m_d2 = m_d1;
         m_d1 = held;
      end
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      held = '0;
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      n_cmp++;
      if (kif.row !== 4'b1110) begin n_bad++; $display("FAIL reset_row: got %b want 1110", kif.row); end
      n_cmp++;
      if (kif.key_out !== 16'h0) begin n_bad++; $display("FAIL reset_key_out: got %h want 0000", kif.key_out); end
      n_cmp++;
      if (kif.key_pulse !== 16'h0) begin n_bad++; $display("FAIL reset_key_pulse: got %h want 0000", kif.key_pulse); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 100; t++) begin
         tick();
         n_cmp++;
         if (kif.row !== exp_row()) begin n_bad++; $display("FAIL idle_row t=%0d: got %b want %b", m_n, kif.row, exp_row()); end
         n_cmp++;
         if (kif.key_out !== 16'h0 || kif.key_pulse !== 16'h0) begin
            n_bad++; $display("FAIL idle_keys t=%0d: got out=%h pulse=%h want 0000/0000", m_n, kif.key_out, kif.key_pulse);
         end
      end
   endtask

   task automatic test_hold_single();
      int n_pulse = 0;
      int t_pulse = -1;
      held = 16'h0020;
      apply_reset();
      for (int t = 0; t < 5 * FRAME; t++) begin
         tick();
         if (kif.key_pulse != 16'h0) begin
            n_pulse++; t_pulse = m_n;
            n_cmp++;
            if (kif.key_pulse !== 16'h0020) begin n_bad++; $display("FAIL hold_pulse_val: got %h want 0020", kif.key_pulse); end
         end
         n_cmp++;
         if (kif.key_out !== m_level) begin n_bad++; $display("FAIL hold_key_out t=%0d: got %h want %h", m_n, kif.key_out, m_level); end
      end
      // Third R1 sample lands on edge 8 + 2*FRAME.
      n_cmp++;
      if (n_pulse != 1 || t_pulse != 8 + 2 * FRAME) begin
         n_bad++; $display("FAIL hold_pulse_timing: got count=%0d edge=%0d want 1/%0d", n_pulse, t_pulse, 8 + 2 * FRAME);
      end
      n_cmp++;
      if (kif.key_out !== 16'h0020) begin n_bad++; $display("FAIL hold_final: got %h want 0020", kif.key_out); end
   endtask

   task automatic test_release();
      int t_fall = -1;
      int s;
      int want;
      held = 16'h0000;
      // First R1 sample edge that sees the release, then two more frames.
      s = m_n + 3;
      while (s % FRAME != 8) s++;
      want = s + 2 * FRAME;
      for (int t = 0; t < 5 * FRAME; t++) begin
         tick();
         if (t_fall < 0 && kif.key_out[5] === 1'b0) t_fall = m_n;
         n_cmp++;
         if (kif.key_pulse !== 16'h0) begin n_bad++; $display("FAIL release_pulse t=%0d: got %h want 0000", m_n, kif.key_pulse); end
      end
      n_cmp++;
      if (t_fall != want) begin n_bad++; $display("FAIL release_timing: got edge=%0d want %0d", t_fall, want); end
      n_cmp++;
      if (kif.key_out !== 16'h0) begin n_bad++; $display("FAIL release_final: got %h want 0000", kif.key_out); end
   endtask

   task automatic test_bounce();
      int n_pulse = 0;
      held = '0;
      apply_reset();
      for (int t = 0; t < 10 * FRAME; t++) begin
         if (t % FRAME == 0) held[14] = ~held[14];
         tick();
         n_cmp++;
         if (kif.key_out[14] !== 1'b0 || kif.key_pulse[14] !== 1'b0) begin
            n_bad++; $display("FAIL bounce_quiet t=%0d: got out=%b pulse=%b want 0/0", m_n, kif.key_out[14], kif.key_pulse[14]);
         end
      end
      held = 16'h4000;
      for (int t = 0; t < 5 * FRAME; t++) begin
         tick();
         if (kif.key_pulse != 16'h0) begin
            n_pulse++;
            n_cmp++;
            if (kif.key_pulse !== 16'h4000) begin n_bad++; $display("FAIL bounce_pulse_val: got %h want 4000", kif.key_pulse); end
         end
      end
      n_cmp++;
      if (n_pulse != 1) begin n_bad++; $display("FAIL bounce_pulse_count: got %0d want 1", n_pulse); end
   endtask

   task automatic test_two_keys();
      logic [15:0] pv [$];
      int          pt [$];
      held = 16'h8008;
      apply_reset();
      for (int t = 0; t < 5 * FRAME; t++) begin
         tick();
         if (kif.key_pulse != 16'h0) begin pv.push_back(kif.key_pulse); pt.push_back(m_n); end
      end
      n_cmp++;
      if (pv.size() != 2) begin
         n_bad++; $display("FAIL two_pulse_count: got %0d want 2", pv.size());
      end else begin
         n_cmp++;
         if (pv[0] !== 16'h0008 || pv[1] !== 16'h8000) begin
            n_bad++; $display("FAIL two_pulse_order: got %h,%h want 0008,8000", pv[0], pv[1]);
         end
         n_cmp++;
         if (pt[1] - pt[0] != 3 * SCAN_DIV) begin
            n_bad++; $display("FAIL two_pulse_gap: got %0d want %0d", pt[1] - pt[0], 3 * SCAN_DIV);
         end
      end
      n_cmp++;
      if (kif.key_out !== 16'h8008) begin n_bad++; $display("FAIL two_final: got %h want 8008", kif.key_out); end
   endtask

   task automatic test_reset_mid();
      int t_rise = -1;
      held = 16'h0001;
      apply_reset();
      // Two R0 samples (edges 4 and 4+FRAME), one short of maturing.
      for (int t = 0; t < FRAME + 8; t++) tick();
      n_cmp++;
      if (kif.key_out[0] !== 1'b0) begin n_bad++; $display("FAIL mid_pre_reset: got %b want 0", kif.key_out[0]); end
      apply_reset();
      n_cmp++;
      if (kif.key_out !== 16'h0 || kif.row !== 4'b1110) begin
         n_bad++; $display("FAIL mid_after_reset: got out=%h row=%b want 0000/1110", kif.key_out, kif.row);
      end
      for (int t = 0; t < 4 * FRAME; t++) begin
         tick();
         if (t_rise < 0 && kif.key_out[0] === 1'b1) t_rise = m_n;
      end
      n_cmp++;
      if (t_rise != 4 + 2 * FRAME) begin n_bad++; $display("FAIL mid_rise_timing: got edge=%0d want %0d", t_rise, 4 + 2 * FRAME); end
   endtask

   task automatic test_random();
      held = '0;
      apply_reset();
      for (int t = 0; t < 3000; t++) begin
         if ($urandom_range(0, 39) == 0) held = 16'($urandom) & 16'($urandom);
         else if ($urandom_range(0, 199) == 0) held[$urandom_range(0, 15)] ^= 1'b1;
         tick();
         n_cmp++;
         if (kif.row !== exp_row() || kif.key_out !== m_level || kif.key_pulse !== m_pulse) begin
            n_bad++;
            $display("FAIL random t=%0d: got row=%b out=%h pulse=%h want row=%b out=%h pulse=%h",
                     m_n, kif.row, kif.key_out, kif.key_pulse, exp_row(), m_level, m_pulse);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_hold_single();
      test_release();
      test_bounce();
      test_two_keys();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
